// File: rtl/npu_pkg.sv
// Shared types and helpers for the NPU symbol-score path.
package npu_pkg;

  localparam int SYMBOL_COUNT = 4;

  typedef logic [1:0] symbol_id_t;

  typedef enum logic [1:0] {
    SYM_DOT,
    SYM_CIRCLE,
    SYM_X,
    SYM_CROSS
  } symbol_e;

  typedef enum logic {
    COLLECTING,
    COMPLETE
  } set_state_e;

  function automatic int clamp_score(input int value, input int max_val);
    if (value < 0) return 0;
    if (value > max_val) return max_val;
    return value;
  endfunction

endpackage

// File: rtl/score_ema.sv
// One committed symbol score: IIR step toward the target, range-clamped, with load/zero controls.
module score_ema
  import npu_pkg::*;
#(
  parameter int SCORE_W     = 16,
  parameter int SCORE_MAX   = 255,
  parameter int ALPHA_SHIFT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               zero_i,
  input  logic [SCORE_W-1:0] target_i,
  output logic [SCORE_W-1:0] value_o
);

  logic [SCORE_W-1:0]        value_q, value_d;
  logic signed [SCORE_W:0]   diff;
  logic signed [SCORE_W:0]   step;
  logic signed [SCORE_W+1:0] sum;

  // Arithmetic shift floors, so small upward steps stall just below the target.
  always_comb begin
    diff    = $signed({1'b0, target_i}) - $signed({1'b0, value_q});
    step    = diff >>> ALPHA_SHIFT;
    sum     = $signed({2'b00, value_q}) + $signed({step[SCORE_W], step});
    value_d = SCORE_W'(clamp_score(int'(sum), SCORE_MAX));
  end

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         value_q <= '0;
    else if (zero_i) value_q <= '0;
    else if (load_i) value_q <= value_d;
  end

  assign value_o = value_q;

endmodule

// File: rtl/symbol_score_latch.sv
// Collects four serial symbol scores per frame and commits them, smoothed, on frame_start;
// a miss watchdog zeroes the outputs when complete sets stop arriving.
module symbol_score_latch
  import npu_pkg::*;
#(
  parameter int SCORE_W     = 16,
  parameter int SCORE_MAX   = 255,
  parameter int ALPHA_SHIFT = 2,
  parameter int MISS_LIMIT  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_start,
  input  logic                      score_valid,
  input  symbol_id_t                score_id,
  input  logic signed [SCORE_W-1:0] score_value,
  output logic [31:0]               symbol_0,
  output logic [31:0]               symbol_1,
  output logic [31:0]               symbol_2,
  output logic [31:0]               symbol_3,
  output logic                      scores_updated,
  output logic                      set_incomplete,
  output logic                      scores_stale
);

  localparam int MISS_W = $clog2(MISS_LIMIT + 1);
  localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(MISS_LIMIT);

  logic [SCORE_W-1:0]      shadow_q [SYMBOL_COUNT];
  logic [SCORE_W-1:0]      value    [SYMBOL_COUNT];
  logic [SYMBOL_COUNT-1:0] got_mask_q, got_mask_d;
  logic [MISS_W-1:0]       miss_q, miss_d;
  logic                    stale_q, stale_d;
  logic                    updated_q, updated_d;
  logic                    incomplete_q, incomplete_d;
  logic                    commit_load, commit_zero, any_nonzero;
  set_state_e              set_state;

  assign set_state = (got_mask_q == '1) ? COMPLETE : COLLECTING;

  // NOTE: the shadow array is small and reset explicitly so a post-reset partial set is never
  // combined with leftovers; larger score memories would normally stay unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYMBOL_COUNT; k++) shadow_q[k] <= '0;
    end else if (score_valid) begin
      shadow_q[score_id] <= SCORE_W'(clamp_score(int'(score_value), SCORE_MAX));
    end
  end

  always_comb begin
    any_nonzero = 1'b0;
    for (int k = 0; k < SYMBOL_COUNT; k++) any_nonzero = any_nonzero | (|value[k]);
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    got_mask_d   = got_mask_q;
    miss_d       = miss_q;
    stale_d      = stale_q;
    updated_d    = 1'b0;
    incomplete_d = 1'b0;
    commit_load  = 1'b0;
    commit_zero  = 1'b0;
    if (frame_start) begin
      if (set_state == COMPLETE) begin
        commit_load = 1'b1;
        updated_d   = 1'b1;
        miss_d      = '0;
        stale_d     = 1'b0;
      end else begin
        incomplete_d = 1'b1;
        if (miss_q < MISS_MAX) miss_d = miss_q + 1'b1;
        if (miss_d == MISS_MAX) begin
          commit_zero = 1'b1;
          stale_d     = 1'b1;
          updated_d   = any_nonzero;
        end
      end
      got_mask_d = '0;
    end
    // A score arriving with frame_start belongs to the new frame's set.
    if (score_valid) got_mask_d = got_mask_d | (SYMBOL_COUNT'(1) << score_id);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      got_mask_q   <= '0;
      miss_q       <= '0;
      stale_q      <= 1'b0;
      updated_q    <= 1'b0;
      incomplete_q <= 1'b0;
    end else begin
      got_mask_q   <= got_mask_d;
      miss_q       <= miss_d;
      stale_q      <= stale_d;
      updated_q    <= updated_d;
      incomplete_q <= incomplete_d;
    end
  end

  for (genvar k = 0; k < SYMBOL_COUNT; k++) begin : g_ema
    score_ema #(
      .SCORE_W    (SCORE_W),
      .SCORE_MAX  (SCORE_MAX),
      .ALPHA_SHIFT(ALPHA_SHIFT)
    ) u_ema (
      .clk     (clk),
      .rst     (rst),
      .load_i  (commit_load),
      .zero_i  (commit_zero),
      .target_i(shadow_q[k]),
      .value_o (value[k])
    );
  end

  assign symbol_0       = 32'(value[SYM_DOT]);
  assign symbol_1       = 32'(value[SYM_CIRCLE]);
  assign symbol_2       = 32'(value[SYM_X]);
  assign symbol_3       = 32'(value[SYM_CROSS]);
  assign scores_updated = updated_q;
  assign set_incomplete = incomplete_q;
  assign scores_stale   = stale_q;

endmodule
